if_id_pipe: RTL and testbench

//  IF->ID pipeline register of the MIPS core. It captures PC, PC+4 and the instruction produced
//  by the IF stage and presents them to the ID stage. It adds a valid/ready handshake and a
//  one-entry skid buffer, so an ID stall never drops an instruction.
//  It also handles branch flush from ID and pre-extracts the common instruction fields.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/if_id_entry.sv | 55 +++++
 rtl/if_id_pipe.sv | 177 +++++++++++++++++
 tb/tb_if_id_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//  Shared constants for the MIPS IF/ID pipeline register.
//  - Word and register-index widths.
//  - The default bubble instruction.
//  - The bit positions of each instruction field.
//  - A helper that sign-extends a 16-bit immediate.
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int INS_W    = 32;
   localparam int REG_W    = 5;

   localparam int OPC_HI   = 31;
   localparam int OPC_LO   = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;
   localparam int IMM_HI   = 15;
   localparam int IMM_LO   = 0;

   localparam logic [INS_W-1:0] NOP_INS_DEF = 32'h0000_0000;

   function automatic logic [INS_W-1:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/if_id_entry.sv
// -----------------------------------------------------------------------------
// if_id_entry
//  Holds one pipeline slot: {valid, pc, next_pc, ins}.
//  - i_load has priority over i_clear.
//  - i_clear drops only the valid bit. The payload is left as it was, so a
//    bubble keeps showing the last PC.
// Ports
//  i_clk, i_rst_n         clock, asynchronous active-low reset
//  i_load, i_clear        capture the d-inputs / invalidate the entry
//  i_pc, i_next_pc, i_ins payload to capture
//  o_valid, o_pc, o_next_pc, o_ins  registered entry contents
// -----------------------------------------------------------------------------
module if_id_entry
   import mips_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_clear,
   input  logic [INS_W-1:0] i_pc,
   input  logic [INS_W-1:0] i_next_pc,
   input  logic [INS_W-1:0] i_ins,
   output logic             o_valid,
   output logic [INS_W-1:0] o_pc,
   output logic [INS_W-1:0] o_next_pc,
   output logic [INS_W-1:0] o_ins
);

   logic             r_valid;
   logic [INS_W-1:0] r_pc;
   logic [INS_W-1:0] r_next_pc;
   logic [INS_W-1:0] r_ins;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid   <= 1'b0;
         r_pc      <= '0;
         r_next_pc <= '0;
         r_ins     <= '0;
      end else if (i_load) begin
         r_valid   <= 1'b1;
         r_pc      <= i_pc;
         r_next_pc <= i_next_pc;
         r_ins     <= i_ins;
      end else if (i_clear) begin
         r_valid   <= 1'b0;
      end
   end

   assign o_valid   = r_valid;
   assign o_pc      = r_pc;
   assign o_next_pc = r_next_pc;
   assign o_ins     = r_ins;

endmodule

// File: rtl/if_id_pipe.sv
// -----------------------------------------------------------------------------
// if_id_pipe
//  IF->ID pipeline register with a valid/ready handshake and a one-entry skid
//  buffer. It also handles the branch flush from ID and decodes the common
//  instruction fields.
//
//  Optional build macro: DELAY_SLOT_EN
//  - When defined, an honoured flush keeps the one next-older instruction,
//    which is the branch delay slot.
//  - When undefined, an honoured flush kills every younger instruction.
//
// Parameters
//  NOP_INS   instruction shown on id_ins while id_valid=0
//  SKID_EN   1: skid entry present, if_ready is registered
//            0: no skid, if_ready follows id_ready combinationally
//
// Ports
//  CLK, RST                           clock, asynchronous active-low reset
//  if_pc, if_next_pc, if_ins          instruction offered by IF
//  if_valid / if_ready                IF-side handshake
//  id_ready                           ID consumes the current output
//  flush                              taken branch/jump in ID
//  id_valid, id_pc, id_next_pc, id_ins  registered output to ID
//  id_opcode, id_rs, id_rt, id_rd, id_funct, id_imm_sext  fields decoded from id_ins
// -----------------------------------------------------------------------------
module if_id_pipe
   import mips_pkg::*;
#(
   parameter logic [INS_W-1:0] NOP_INS = NOP_INS_DEF,
   parameter bit               SKID_EN = 1'b1
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic [INS_W-1:0] if_pc,
   input  logic [INS_W-1:0] if_next_pc,
   input  logic [INS_W-1:0] if_ins,
   input  logic             if_valid,
   output logic             if_ready,
   input  logic             id_ready,
   input  logic             flush,
   output logic             id_valid,
   output logic [INS_W-1:0] id_pc,
   output logic [INS_W-1:0] id_next_pc,
   output logic [INS_W-1:0] id_ins,
   output logic [5:0]       id_opcode,
   output logic [REG_W-1:0] id_rs,
   output logic [REG_W-1:0] id_rt,
   output logic [REG_W-1:0] id_rd,
   output logic [5:0]       id_funct,
   output logic [INS_W-1:0] id_imm_sext
);

   logic             w_main_valid;
   logic [INS_W-1:0] w_main_pc;
   logic [INS_W-1:0] w_main_next_pc;
   logic [INS_W-1:0] w_main_ins;
   logic             w_skid_valid;
   logic [INS_W-1:0] w_skid_pc;
   logic [INS_W-1:0] w_skid_next_pc;
   logic [INS_W-1:0] w_skid_ins;

   logic             w_accept;
   logic             w_advance;
   logic             w_flush;
   logic             w_main_free;
   logic             w_main_load;
   logic             w_main_clear;
   logic             w_main_from_skid;
   logic             w_skid_load;
   logic             w_skid_clear;
   logic [INS_W-1:0] w_main_d_pc;
   logic [INS_W-1:0] w_main_d_next_pc;
   logic [INS_W-1:0] w_main_d_ins;

   assign w_accept    = if_valid & if_ready;
   assign w_advance   = w_main_valid & id_ready;
   // A flush only counts when the branch actually leaves ID this cycle.
   assign w_flush     = flush & w_advance;
   assign w_main_free = ~w_main_valid | w_advance;

   always_comb begin
      w_main_load      = 1'b0;
      w_main_clear     = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_load      = 1'b0;
      w_skid_clear     = 1'b0;
      if (w_main_free) begin
         // The skid entry is older than anything IF offers. While the skid
         // is full, if_ready is low, so no new word can compete with it.
         if (w_skid_valid) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
         end else if (w_accept) begin
            w_main_load = 1'b1;
         end else begin
            w_main_clear = 1'b1;
         end
      end else if (w_accept) begin
         w_skid_load = 1'b1;
      end
`ifdef DELAY_SLOT_EN
      // The normal advance path already keeps exactly one instruction, the
      // delay slot: either skid->main or the word accepted this cycle. A
      // flush never parks a word in the skid. Main is always free on a flush,
      // so this override is redundant and only states the intent.
      if (w_flush) begin
         w_skid_load = 1'b0;
      end
`else
      // Kill everything younger than the departing branch.
      if (w_flush) begin
         w_main_load  = 1'b0;
         w_main_clear = 1'b1;
         w_skid_load  = 1'b0;
         w_skid_clear = 1'b1;
      end
`endif
   end

   assign w_main_d_pc      = w_main_from_skid ? w_skid_pc      : if_pc;
   assign w_main_d_next_pc = w_main_from_skid ? w_skid_next_pc : if_next_pc;
   assign w_main_d_ins     = w_main_from_skid ? w_skid_ins     : if_ins;

   if_id_entry u_main (
      .i_clk     (CLK),
      .i_rst_n   (RST),
      .i_load    (w_main_load),
      .i_clear   (w_main_clear),
      .i_pc      (w_main_d_pc),
      .i_next_pc (w_main_d_next_pc),
      .i_ins     (w_main_d_ins),
      .o_valid   (w_main_valid),
      .o_pc      (w_main_pc),
      .o_next_pc (w_main_next_pc),
      .o_ins     (w_main_ins)
   );

   generate
      if (SKID_EN) begin : g_skid
         if_id_entry u_skid (
            .i_clk     (CLK),
            .i_rst_n   (RST),
            .i_load    (w_skid_load),
            .i_clear   (w_skid_clear),
            .i_pc      (if_pc),
            .i_next_pc (if_next_pc),
            .i_ins     (if_ins),
            .o_valid   (w_skid_valid),
            .o_pc      (w_skid_pc),
            .o_next_pc (w_skid_next_pc),
            .o_ins     (w_skid_ins)
         );
         // Driven only by a flop output, so there is no path from id_ready.
         assign if_ready = ~w_skid_valid;
      end else begin : g_no_skid
         assign w_skid_valid   = 1'b0;
         assign w_skid_pc      = '0;
         assign w_skid_next_pc = '0;
         assign w_skid_ins     = '0;
         assign if_ready       = w_main_free;
      end
   endgenerate

   assign id_valid    = w_main_valid;
   assign id_pc       = w_main_pc;
   assign id_next_pc  = w_main_next_pc;
   assign id_ins      = w_main_valid ? w_main_ins : NOP_INS;

   assign id_opcode   = id_ins[OPC_HI:OPC_LO];
   assign id_rs       = id_ins[RS_HI:RS_LO];
   assign id_rt       = id_ins[RT_HI:RT_LO];
   assign id_rd       = id_ins[RD_HI:RD_LO];
   assign id_funct    = id_ins[FUNCT_HI:FUNCT_LO];
   assign id_imm_sext = sext16(id_ins[IMM_HI:IMM_LO]);

endmodule

// File: tb/tb_if_id_pipe.sv
// -----------------------------------------------------------------------------
// tb_if_id_pipe
//  Self-checking bench for if_id_pipe.
//  - Directed vectors carry hand-decoded field values.
//  - The stimulus side pushes the expected output when IF's word is accepted.
//  - A monitor pops the queue and compares whenever ID consumes an output.
// -----------------------------------------------------------------------------
module tb_if_id_pipe;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] npc;
      logic [31:0] ins;
      logic [5:0]  opc;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [5:0]  funct;
      logic [31:0] imm;
   } exp_t;

`ifdef DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] if_pc = '0;
   logic [31:0] if_next_pc = '0;
   logic [31:0] if_ins = '0;
   logic        if_valid = 1'b0;
   logic        if_ready;
   logic        id_ready = 1'b0;
   logic        flush = 1'b0;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_next_pc;
   logic [31:0] id_ins;
   logic [5:0]  id_opcode;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [5:0]  id_funct;
   logic [31:0] id_imm_sext;

   int checks   = 0;
   int failures = 0;
   exp_t sb[$];
   exp_t mon_e;

   // Hand-decoded vectors: pc, pc+4, ins, opcode, rs, rt, rd, funct, imm_sext
   exp_t e_a   = '{32'h00, 32'h04, 32'h8C010004, 6'h23, 5'd0, 5'd1, 5'd0,  6'h04, 32'h00000004};
   exp_t e_b   = '{32'h04, 32'h08, 32'h00221820, 6'h00, 5'd1, 5'd2, 5'd3,  6'h20, 32'h00001820};
   exp_t e_c   = '{32'h08, 32'h0C, 32'hAC030008, 6'h2B, 5'd0, 5'd3, 5'd0,  6'h08, 32'h00000008};
   exp_t e_10  = '{32'h10, 32'h14, 32'h2001FFFC, 6'h08, 5'd0, 5'd1, 5'd31, 6'h3C, 32'hFFFFFFFC};
   exp_t e_14  = '{32'h14, 32'h18, 32'h00851020, 6'h00, 5'd4, 5'd5, 5'd2,  6'h20, 32'h00001020};
   exp_t e_br  = '{32'h20, 32'h24, 32'h10220003, 6'h04, 5'd1, 5'd2, 5'd0,  6'h03, 32'h00000003};
   exp_t e_24  = '{32'h24, 32'h28, 32'h3C01ABCD, 6'h0F, 5'd0, 5'd1, 5'd21, 6'h0D, 32'hFFFFABCD};
   exp_t e_28  = '{32'h28, 32'h2C, 32'h8C220000, 6'h23, 5'd1, 5'd2, 5'd0,  6'h00, 32'h00000000};
   exp_t e_30  = '{32'h30, 32'h34, 32'h20420001, 6'h08, 5'd2, 5'd2, 5'd0,  6'h01, 32'h00000001};
   exp_t e_40  = '{32'h40, 32'h44, 32'h00000020, 6'h00, 5'd0, 5'd0, 5'd0,  6'h20, 32'h00000020};
   exp_t e_44  = '{32'h44, 32'h48, 32'h00000021, 6'h00, 5'd0, 5'd0, 5'd0,  6'h21, 32'h00000021};

   if_id_pipe dut (
      .CLK         (CLK),
      .RST         (RST),
      .if_pc       (if_pc),
      .if_next_pc  (if_next_pc),
      .if_ins      (if_ins),
      .if_valid    (if_valid),
      .if_ready    (if_ready),
      .id_ready    (id_ready),
      .flush       (flush),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_next_pc  (id_next_pc),
      .id_ins      (id_ins),
      .id_opcode   (id_opcode),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_rd       (id_rd),
      .id_funct    (id_funct),
      .id_imm_sext (id_imm_sext)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: ID consumes the output on the coming edge when id_valid & id_ready.
   always @(negedge CLK) begin
      if (RST && id_valid && id_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow actual pc=%h required=no output", id_pc);
         end else begin
            mon_e = sb.pop_front();
            chk("out_pc",     id_pc,              mon_e.pc);
            chk("out_npc",    id_next_pc,         mon_e.npc);
            chk("out_ins",    id_ins,             mon_e.ins);
            chk("out_opcode", 32'(id_opcode),     32'(mon_e.opc));
            chk("out_rs",     32'(id_rs),         32'(mon_e.rs));
            chk("out_rt",     32'(id_rt),         32'(mon_e.rt));
            chk("out_rd",     32'(id_rd),         32'(mon_e.rd));
            chk("out_funct",  32'(id_funct),      32'(mon_e.funct));
            chk("out_imm",    id_imm_sext,        mon_e.imm);
            $display("txn id_pc=%h id_ins=%h exp_pc=%h", id_pc, id_ins, mon_e.pc);
         end
      end
   end

   // One cycle of stimulus, entered and left at posedge+1.
   task automatic step(input bit v, input exp_t e, input bit rdy, input bit fl,
                       input bit push, output bit acc);
      if_valid   = v;
      if_pc      = e.pc;
      if_next_pc = e.npc;
      if_ins     = e.ins;
      id_ready   = rdy;
      flush      = fl;
      acc = v && (if_ready === 1'b1);
      if (acc && push) sb.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input bit rdy);
      bit acc;
      step(1'b0, e_a, rdy, 1'b0, 1'b0, acc);
   endtask

   task automatic offer_until(input exp_t e, input bit rdy);
      bit acc;
      for (int n = 0; n < 20; n++) begin
         step(1'b1, e, rdy, 1'b0, 1'b1, acc);
         if (acc) return;
      end
      chk("offer_timeout", 32'(acc), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      // Reset state
      #1;
      chk("rst_valid", 32'(id_valid), 32'd0);
      chk("rst_ins",   id_ins,        32'h0);
      chk("rst_pc",    id_pc,         32'h0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      chk("rel_if_ready", 32'(if_ready), 32'd1);

      // Stream
      offer_until(e_a, 1'b1);
      chk("lat_valid", 32'(id_valid), 32'd1);
      chk("lat_pc",    id_pc,         32'h00);
      chk("lat_rs",    32'(id_rs),    32'd0);
      chk("lat_rt",    32'(id_rt),    32'd1);
      offer_until(e_b, 1'b1);
      offer_until(e_c, 1'b1);

      // Stall: 0x08 held in main, 0x10 goes to skid, 0x14 must wait
      step(1'b1, e_10, 1'b0, 1'b0, 1'b1, acc);
      chk("stall_acc10",   32'(acc),      32'd1);
      chk("stall_if_rdy",  32'(if_ready), 32'd0);
      chk("stall_pc_held", id_pc,         32'h08);
      step(1'b1, e_14, 1'b0, 1'b0, 1'b1, acc);
      step(1'b1, e_14, 1'b0, 1'b0, 1'b1, acc);
      chk("stall_if_rdy2", 32'(if_ready), 32'd0);
      offer_until(e_14, 1'b1);
      idle(1'b1);
      chk("drain_valid", 32'(id_valid), 32'd0);
      chk("bubble_ins",  id_ins,        32'h0);

      // Flush with branch in main and 0x24 in skid
      step(1'b1, e_br, 1'b0, 1'b0, 1'b1, acc);
      step(1'b1, e_24, 1'b0, 1'b0, DS, acc);
      chk("fl_skid_full", 32'(if_ready), 32'd0);
      step(1'b1, e_28, 1'b1, 1'b1, 1'b1, acc);
      chk("fl_no_accept", 32'(acc), 32'd0);
`ifdef DELAY_SLOT_EN
      chk("fl_ds_valid", 32'(id_valid), 32'd1);
      chk("fl_ds_pc",    id_pc,         32'h24);
`else
      chk("fl_valid",    32'(id_valid), 32'd0);
`endif
      chk("fl_if_ready", 32'(if_ready), 32'd1);
      idle(1'b1);
      chk("fl_drained", 32'(id_valid), 32'd0);

      // Flush with skid empty: the word accepted with the flush
      step(1'b1, e_br, 1'b0, 1'b0, 1'b1, acc);
      step(1'b1, e_28, 1'b1, 1'b1, DS, acc);
      chk("fl2_accepted", 32'(acc), 32'd1);
      chk("fl2_valid", 32'(id_valid), 32'(DS));
      idle(1'b1);

      // Ignored flush while ID stalls
      step(1'b1, e_30, 1'b0, 1'b0, 1'b1, acc);
      step(1'b0, e_30, 1'b0, 1'b1, 1'b0, acc);
      chk("ign_valid", 32'(id_valid), 32'd1);
      chk("ign_pc",    id_pc,         32'h30);
      step(1'b0, e_30, 1'b0, 1'b1, 1'b0, acc);
      chk("ign_pc2",   id_pc,         32'h30);
      chk("ign_ins",   id_ins,        32'h20420001);
      idle(1'b1);

      // Reset mid-stream with main and skid full
      step(1'b1, e_40, 1'b0, 1'b0, 1'b1, acc);
      step(1'b1, e_44, 1'b0, 1'b0, 1'b1, acc);
      chk("pre_rst_full", 32'(if_ready), 32'd0);
      if_valid = 1'b0;
      RST = 1'b0;
      #1;
      chk("arst_valid", 32'(id_valid), 32'd0);
      chk("arst_ins",   id_ins,        32'h0);
      chk("arst_pc",    id_pc,         32'h0);
      chk("arst_npc",   id_next_pc,    32'h0);
      sb.delete();
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      chk("arel_if_ready", 32'(if_ready), 32'd1);
      chk("arel_valid",    32'(id_valid), 32'd0);

      // Recovery after reset
      offer_until(e_10, 1'b1);
      idle(1'b1);
      idle(1'b1);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
